// File: rtl/bullet_hit_detector_if.sv
// Raster-side bundle between the VGA scan / sprite logic and the hit detector.
// The slave side is the detector; the master side drives pixels and receives results.
interface bullet_hit_detector_if #(
  parameter int N_BUL = 4,
  parameter int N_AST = 8,
  parameter int CNT_W = 16
);
  logic [9:0]       px;
  logic [9:0]       py;
  logic             frame_tick;
  logic [N_BUL-1:0] bullet_pixel;
  logic [N_BUL-1:0] bullet_inUse;
  logic [N_AST-1:0] ast_pixel;
  logic             ship_pixel;
  logic [N_BUL-1:0] bullet_reset;
  logic [N_AST-1:0] ast_hit;
  logic             ship_hit;
  logic [CNT_W-1:0] destroyed;
  logic             frame_valid;

  modport slave (
    input  px, py, frame_tick, bullet_pixel, bullet_inUse, ast_pixel, ship_pixel,
    output bullet_reset, ast_hit, ship_hit, destroyed, frame_valid
  );

  modport master (
    output px, py, frame_tick, bullet_pixel, bullet_inUse, ast_pixel, ship_pixel,
    input  bullet_reset, ast_hit, ship_hit, destroyed, frame_valid
  );
endinterface

// File: rtl/bullet_hit_detector.sv
// Accumulates bullet/asteroid/ship pixel coincidences over a frame and commits
// them as frame-long level outputs at each frame boundary.
module bullet_hit_detector #(
  parameter int N_BUL    = 4,
  parameter int N_AST    = 8,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  bullet_hit_detector_if.slave  bus
);
  localparam logic [9:0] LP_H_ACTIVE = 10'(H_ACTIVE);
  localparam logic [9:0] LP_V_ACTIVE = 10'(V_ACTIVE);

  typedef enum logic [1:0] {
    ST_WAIT_SYNC = 2'd0,
    ST_SCAN      = 2'd1,
    ST_COMMIT    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [N_BUL-1:0] r_acc_bul;
  logic [N_AST-1:0] r_acc_ast;
  logic             r_acc_ship;
  logic [N_BUL-1:0] r_bullet_reset;
  logic [N_AST-1:0] r_ast_hit;
  logic             r_ship_hit;
  logic [CNT_W-1:0] r_destroyed;
  logic             r_frame_valid;

  logic [N_BUL-1:0] w_b_live;
  logic             w_any_ast;
  logic             w_any_bul;
  logic             w_acc_en;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_destroyed_next;

  function automatic logic [CNT_W:0] popcount(input logic [N_AST-1:0] v);
    logic [CNT_W:0] c;
    c = '0;
    for (int k = 0; k < N_AST; k++) begin
      c = c + {{CNT_W{1'b0}}, v[k]};
    end
    return c;
  endfunction

  assign w_b_live  = bus.bullet_pixel & bus.bullet_inUse;
  assign w_any_ast = |bus.ast_pixel;
  assign w_any_bul = |w_b_live;
  assign w_acc_en  = (r_state == ST_SCAN) && !bus.frame_tick &&
                     (bus.px < LP_H_ACTIVE) && (bus.py < LP_V_ACTIVE);

  // Saturating add: a carry out of the counter width pins it at all-ones.
  assign w_sum            = {1'b0, r_destroyed} + popcount(r_acc_ast);
  assign w_destroyed_next = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

  // Next-state logic for the frame-synchronisation FSM.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_WAIT_SYNC: begin
        if (bus.frame_tick) w_state_next = ST_SCAN;
        else                w_state_next = ST_WAIT_SYNC;
      end
      ST_SCAN: begin
        if (bus.frame_tick) w_state_next = ST_COMMIT;
        else                w_state_next = ST_SCAN;
      end
      ST_COMMIT: w_state_next = ST_SCAN;
      default:   w_state_next = ST_WAIT_SYNC;
    endcase
  end

  // State register, sticky accumulators and committed result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_WAIT_SYNC;
      r_acc_bul      <= '0;
      r_acc_ast      <= '0;
      r_acc_ship     <= 1'b0;
      r_bullet_reset <= '0;
      r_ast_hit      <= '0;
      r_ship_hit     <= 1'b0;
      r_destroyed    <= '0;
      r_frame_valid  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_COMMIT) begin
        r_bullet_reset <= r_acc_bul;
        r_ast_hit      <= r_acc_ast;
        r_ship_hit     <= r_acc_ship;
        r_destroyed    <= w_destroyed_next;
        r_frame_valid  <= 1'b1;
        r_acc_bul      <= '0;
        r_acc_ast      <= '0;
        r_acc_ship     <= 1'b0;
      end else if (w_acc_en) begin
        r_acc_bul  <= r_acc_bul | (w_b_live & {N_BUL{w_any_ast}});
        r_acc_ast  <= r_acc_ast | (bus.ast_pixel & {N_AST{w_any_bul}});
        r_acc_ship <= r_acc_ship | (bus.ship_pixel & w_any_ast);
      end else begin
        r_acc_bul  <= r_acc_bul;
        r_acc_ast  <= r_acc_ast;
        r_acc_ship <= r_acc_ship;
      end
    end
  end

  assign bus.bullet_reset = r_bullet_reset;
  assign bus.ast_hit      = r_ast_hit;
  assign bus.ship_hit     = r_ship_hit;
  assign bus.destroyed    = r_destroyed;
  assign bus.frame_valid  = r_frame_valid;
endmodule

// File: tb/tb_bullet_hit_detector.sv
// Directed plus randomized bench for bullet_hit_detector; expected results come
// from a pairwise bullet/asteroid overlap model evaluated per frame.
module tb_bullet_hit_detector;
  logic clk;
  logic reset;

  bullet_hit_detector_if #(.N_BUL(4), .N_AST(8), .CNT_W(16)) bus ();

  bullet_hit_detector #(
    .N_BUL(4), .N_AST(8), .H_ACTIVE(640), .V_ACTIVE(480), .CNT_W(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit       m_synced;
  bit [3:0] m_bul;
  bit [7:0] m_ast;
  bit       m_ship;
  bit [3:0] e_bul;
  bit [7:0] e_ast;
  bit       e_ship;
  int       e_destroyed;
  bit       e_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".bullet_reset"}, {28'd0, bus.bullet_reset}, {28'd0, e_bul});
    chk({tag, ".ast_hit"},      {24'd0, bus.ast_hit},      {24'd0, e_ast});
    chk({tag, ".ship_hit"},     {31'd0, bus.ship_hit},     {31'd0, e_ship});
    chk({tag, ".destroyed"},    {16'd0, bus.destroyed},    e_destroyed);
    chk({tag, ".frame_valid"},  {31'd0, bus.frame_valid},  {31'd0, e_valid});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_synced = 1'b0; m_bul = '0; m_ast = '0; m_ship = 1'b0;
    e_bul = '0; e_ast = '0; e_ship = 1'b0; e_destroyed = 0; e_valid = 1'b0;
  endtask

  // one scan cycle; the model checks every bullet/asteroid pair directly
  task automatic pix(input int x, input int y, input bit [3:0] bp, input bit [3:0] bu,
                     input bit [7:0] ap, input bit sp);
    bus.px = 10'(x); bus.py = 10'(y); bus.frame_tick = 1'b0;
    bus.bullet_pixel = bp; bus.bullet_inUse = bu; bus.ast_pixel = ap; bus.ship_pixel = sp;
    if (m_synced && x < 640 && y < 480) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 8; j++)
          if (bp[i] && bu[i] && ap[j]) begin
            m_bul[i] = 1'b1;
            m_ast[j] = 1'b1;
          end
      for (int j = 0; j < 8; j++)
        if (sp && ap[j]) m_ship = 1'b1;
    end
    step();
  endtask

  // frame_tick with junk pixels (must be ignored), then one quiet cycle
  task automatic tick(input string tag, input bit do_check);
    bus.frame_tick = 1'b1;
    bus.px = 10'd10; bus.py = 10'd10;
    bus.bullet_pixel = 4'hF; bus.bullet_inUse = 4'hF; bus.ast_pixel = 8'hFF; bus.ship_pixel = 1'b1;
    step();
    if (m_synced) begin
      e_bul = m_bul; e_ast = m_ast; e_ship = m_ship; e_valid = 1'b1;
      e_destroyed = e_destroyed + $countones(m_ast);
      if (e_destroyed > 65535) e_destroyed = 65535;
    end
    m_synced = 1'b1; m_bul = '0; m_ast = '0; m_ship = 1'b0;
    bus.frame_tick = 1'b0;
    bus.bullet_pixel = '0; bus.bullet_inUse = '0; bus.ast_pixel = '0; bus.ship_pixel = 1'b0;
    step();
    if (do_check) check_all(tag);
  endtask

  initial begin
    int d0;
    bit [7:0] mask;
    reset = 1'b1;
    bus.px = '0; bus.py = '0; bus.frame_tick = 1'b0;
    bus.bullet_pixel = '0; bus.bullet_inUse = '0; bus.ast_pixel = '0; bus.ship_pixel = 1'b0;
    model_reset();
    step(); step();
    reset = 1'b0;
    check_all("reset");

    // WAIT_SYNC ignores overlaps
    for (int k = 0; k < 5; k++) pix(100, 100, 4'b0001, 4'b0001, 8'h01, 1'b0);
    check_all("wait_sync");

    tick("sync_tick", 1'b1);
    pix(320, 240, 4'b0100, 4'b0100, 8'h20, 1'b0);
    tick("single_hit", 1'b1);
    chk("single_hit.lit_bul", {28'd0, bus.bullet_reset}, 32'h4);
    chk("single_hit.lit_ast", {24'd0, bus.ast_hit}, 32'h20);
    chk("single_hit.lit_cnt", {16'd0, bus.destroyed}, 32'd1);
    pix(5, 5, 4'b0000, 4'b0000, 8'h00, 1'b0);
    check_all("held_mid_frame");
    tick("empty_frame", 1'b1);

    // blanking and not-in-use overlaps
    pix(700, 100, 4'b0001, 4'b0001, 8'h01, 1'b0);
    pix(100, 500, 4'b0010, 4'b0010, 8'h02, 1'b0);
    pix(100, 100, 4'b0001, 4'b1110, 8'h01, 1'b0);
    tick("no_hits", 1'b1);

    // multi-object overlaps, repeated over 50 pixels
    d0 = e_destroyed;
    for (int k = 0; k < 50; k++) begin
      pix(200 + k, 50, 4'b0001, 4'b1111, 8'h0A, 1'b0);
      pix(200 + k, 60, 4'b1010, 4'b1111, 8'h40, 1'b0);
    end
    tick("multi", 1'b1);
    chk("multi.lit_bul", {28'd0, bus.bullet_reset}, 32'hB);
    chk("multi.lit_ast", {24'd0, bus.ast_hit}, 32'h4A);
    chk("multi.lit_cnt", {16'd0, bus.destroyed}, d0 + 3);

    // ship collides with asteroid 0, no live bullets
    pix(300, 300, 4'b0001, 4'b0000, 8'h01, 1'b1);
    tick("ship", 1'b1);
    chk("ship.lit", {31'd0, bus.ship_hit}, 32'd1);

    // randomized frames
    for (int f = 0; f < 25; f++) begin
      for (int k = 0; k < 30; k++)
        pix($urandom_range(0, 799), $urandom_range(0, 524), 4'($urandom), 4'($urandom),
            8'($urandom) & 8'($urandom), 1'($urandom));
      check_all("rand_hold");
      tick("rand_frame", 1'b1);
    end

    // preload the counter towards 0xFFFE
    while (e_destroyed + 8 <= 65534) begin
      pix(10, 10, 4'b0001, 4'b0001, 8'hFF, 1'b0);
      tick("preload", 1'b0);
    end
    mask = 8'((1 << (65534 - e_destroyed)) - 1);
    pix(10, 10, 4'b0001, 4'b0001, mask, 1'b0);
    tick("preload_end", 1'b1);
    chk("preload.lit", {16'd0, bus.destroyed}, 32'hFFFE);
    pix(10, 10, 4'b0001, 4'b0001, 8'h07, 1'b0);
    tick("saturate", 1'b1);
    chk("saturate.lit", {16'd0, bus.destroyed}, 32'hFFFF);
    pix(10, 10, 4'b0001, 4'b0001, 8'h07, 1'b0);
    tick("saturate_hold", 1'b1);

    // reset asserted during COMMIT wins
    pix(10, 10, 4'b0001, 4'b0001, 8'h03, 1'b0);
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    reset = 1'b1;
    step();
    model_reset();
    check_all("reset_in_commit");
    reset = 1'b0;
    pix(100, 100, 4'b0001, 4'b0001, 8'h01, 1'b0);
    check_all("post_reset_wait");
    tick("post_reset_sync", 1'b1);
    pix(100, 100, 4'b0001, 4'b0001, 8'h01, 1'b0);
    tick("post_reset_hit", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bullet_hit_detector.md
Name: bullet_hit_detector

Overview:
Raster-time collision detector that closes the loop with the bullet manager. It consumes the per-bullet pixel and inUse vectors, the per-asteroid pixel vector and the ship pixel during the VGA scan, and accumulates pixel coincidences over a frame. At each frame boundary it commits the results as frame-long level outputs:
- bullet reset vector, fed back to the bullet manager;
- asteroid hit vector;
- ship hit flag;
- saturating destroyed-asteroid counter.

Parameters:
N_BUL, 4, number of bullets (width of bullet pixel/inUse/reset vectors)
N_AST, 8, number of asteroids
H_ACTIVE, 640, visible pixels per line; px >= H_ACTIVE is blanking
V_ACTIVE, 480, visible lines; py >= V_ACTIVE is blanking
CNT_W, 16, width of destroyed counter

Ports:
clk  input  1  pixel clock
reset  input  1  synchronous, active-high
px  input  10  current pixel column
py  input  10  current pixel row
frame_tick  input  1  one-cycle pulse once per frame, during vertical blanking
bullet_pixel  input  N_BUL  bullet i draws at (px,py)
bullet_inUse  input  N_BUL  bullet i is in flight
ast_pixel  input  N_AST  asteroid j draws at (px,py)
ship_pixel  input  1  ship draws at (px,py)
bullet_reset  output  N_BUL  level, held one full frame; drives bullet manager reset
ast_hit  output  N_AST  level, held one full frame; asteroid j was hit last frame
ship_hit  output  1  level, held one full frame
destroyed  output  CNT_W  running count of asteroid hits, saturating
frame_valid  output  1  high once the first frame has been committed

Behaviour:
- Reset (synchronous, active-high):
  - All outputs go to 0.
  - Accumulators clear.
  - State becomes WAIT_SYNC.
- States: WAIT_SYNC, SCAN, COMMIT.
  - WAIT_SYNC: ignores pixels. Moves to SCAN on frame_tick, so accumulation always covers whole frames. Outputs hold 0.
  - SCAN: each cycle with px < H_ACTIVE, py < V_ACTIVE and frame_tick = 0, compute in a single cycle:
    - b_live = bullet_pixel & bullet_inUse.
    - any_ast = OR(ast_pixel).
    - any_bul = OR(b_live).
    - Sticky set: acc_bul[i] |= b_live[i] & any_ast.
    - Sticky set: acc_ast[j] |= ast_pixel[j] & any_bul.
    - Sticky set: acc_ship |= ship_pixel & any_ast.
  - Off-screen cycles do not accumulate.
  - On frame_tick in SCAN, go to COMMIT. Pixel inputs on the tick cycle are ignored.
  - COMMIT (exactly one cycle), at its clock edge:
    - bullet_reset <= acc_bul, ast_hit <= acc_ast, ship_hit <= acc_ship.
    - destroyed <= min(destroyed + popcount(acc_ast), 2^CNT_W - 1).
    - frame_valid <= 1.
    - All accumulators cleared.
    - Next state is SCAN.
  - A frame_tick arriving during COMMIT is ignored (cannot occur with a legal timing generator).
- Latency:
  - A hit in frame N appears on the outputs on the cycle after COMMIT, i.e. 2 cycles after frame N's closing frame_tick.
  - Outputs stay constant until the next COMMIT, one frame later. This lets the 60 Hz bullet logic sample bullet_reset reliably.
- Multi-object rules:
  - One bullet overlapping k asteroids sets all k ast_hit bits.
  - One asteroid hit by several bullets resets all those bullets and counts once.
  - Hits are sticky per frame: repeat overlaps within a frame count once.
- Bullets with inUse=0 never register hits, even if their pixel bit is 1.
- destroyed never wraps. At 2^CNT_W - 1 it holds.
- Reset asserted in any state, including mid-COMMIT, wins: everything returns to the reset values and the state is WAIT_SYNC.

Test Plan:
- Reset then no frame_tick, with bullet_pixel=4'b0001, inUse=4'b0001 and ast_pixel=8'h01 at px=100, py=100 → outputs remain 0 and frame_valid=0 (WAIT_SYNC).
- Tick, then one overlap of bullet 2 (inUse=4'b0100) with asteroid 5 at px=320, py=240, then tick → 2 cycles after the second tick: bullet_reset=4'b0100, ast_hit=8'h20, destroyed=1, frame_valid=1. After the third tick with no overlaps, bullet_reset=0 and ast_hit=0, destroyed stays 1.
- Overlap at px=700 (blanking), and an overlap with inUse[0]=0 → no hits recorded.
- Bullet 0 overlaps asteroids 1 and 3; bullets 1 and 3 both overlap asteroid 6; each overlap is repeated over 50 pixels → bullet_reset=4'b1011, ast_hit=8'h4A, destroyed increments by exactly 3.
- Ship pixel coincides with asteroid 0 while no bullets are live → ship_hit=1, ast_hit=0, destroyed unchanged.
- Preload the counter to 0xFFFE via frames, then a frame with 3 asteroid hits → destroyed=0xFFFF. Reset asserted on the COMMIT cycle → all outputs 0 next cycle, state WAIT_SYNC.
